spi_ss_ctrl: RTL and testbench
==============================

// Module: spi_ss_ctrl
// PURPOSE
//  Slave-select and transfer-timing controller for the APB-SPI master.
//  - Starts one 8-bit transfer window on a send_data_i request and drives ss_o low for its length.
//  - Asserts tip_o while the transfer is in progress and pulses receive_data_o at completion.
//  - Sits between the APB register block (mode/divisor/control) and the SPI shifter/baud generator.
// PARAMETERS
//  DATA_BITS   8    bits per transfer; window length = DATA_BITS * divisor PCLK cycles
//  CNT_W       16   width of internal window counter (>= clog2(DATA_BITS*4095)+1)
// PORTS
//  PCLK               in   1   system clock; all logic on rising edge
//  PRESET_n           in   1   reset, synchronous, active-low
//  mstr_i             in   1   1 = master mode enabled
//  spiswai_i          in   1   1 = SPI stops while in wait mode
//  spi_mode_i         in   2   00 run, 01 wait, 10/11 stop
//  send_data_i        in   1   transfer request (level or 1-cycle pulse)
//  BaudRateDivisor_i  in   12  PCLK cycles per SCLK period
//  ss_o               out  1   slave select, active-low
//  tip_o              out  1   transfer in progress (= ~ss_o)
//  receive_data_o     out  1   1-cycle pulse: transfer complete, rx data valid
// BEHAVIOUR
//  - Reset (PRESET_n=0 at PCLK edge): ss_o=1, tip_o=0, receive_data_o=0, counter=0, state IDLE.
//  - enable = mstr_i & (spi_mode_i==00 | (spi_mode_i==01 & ~spiswai_i)).
//  - Effective divisor div = (BaudRateDivisor_i<2) ? 2 : BaudRateDivisor_i.
//    Sampled at transfer start, held constant for the window.
//  - target = DATA_BITS*div, computed at CNT_W width, no overflow for 12-bit input.
//  - IDLE: if enable & send_data_i at edge -> next cycle ss_o=0, tip_o=1, counter=0, state BUSY.
//  - BUSY: counter increments each cycle.
//    - When counter==target-1: next cycle ss_o=1, tip_o=0, receive_data_o=1 for exactly 1 cycle, state IDLE.
//    - ss_o is therefore low for exactly target cycles.
//  - send_data_i while BUSY ignored; a request still high in the cycle receive_data_o pulses starts a new window next cycle.
//  - send_data_i while ~enable in IDLE ignored (not queued).
//  - Reset mid-transfer: outputs return to reset values at that edge; no receive_data_o pulse.
//  - Changes to mstr_i/spi_mode_i/spiswai_i during BUSY: window completes normally (see CONFIGURATION).
//  - All outputs registered; no combinational path input->output.
// CONFIGURATION
//  SPI_SS_ABORT_EN
//  - defined: enable falling during BUSY aborts the window.
//    Next cycle ss_o=1, tip_o=0, counter=0, no receive_data_o pulse, state IDLE.
//  - undefined: window always runs to completion once started.
// TESTING
//  1 Reset: PRESET_n=0 for 2 edges -> ss_o=1, tip_o=0, receive_data_o=0.
//  2 Run: mode=00, mstr=1, div=4, send_data pulse 1 cycle -> ss_o low exactly 32 cycles.
//    tip_o high during same cycles; receive_data_o 1-cycle pulse on the cycle ss_o rises.
//  3 Gating: mode=01 with spiswai=1, or mstr=0, or mode=10, send_data=1 -> ss_o stays 1, no pulse.
//    mode=01 with spiswai=0 -> transfer runs.
//  4 Divisor edge: div=0 and div=1 -> window 16 cycles; div=4095 -> window 32760 cycles, no wrap.
//  5 Busy request/divisor change: send_data held high, div changed 4->8 mid-window.
//    -> first window 32 cycles; second window of 64 starts the cycle after the receive_data_o pulse.
//  6 Abort: mstr dropped at cycle 10 of a div=4 window.
//    -> with SPI_SS_ABORT_EN: ss_o high next cycle, no pulse.
//    -> without: completes at 32 cycles with pulse.
//    Reset at cycle 10 in both builds -> reset values, no pulse.

Source files
------------

// File: rtl/spi_ss_ctrl.sv
// Slave-select / transfer-window timing for the APB-SPI master.
// Build option: define SPI_SS_ABORT_EN to abort a window when enable drops.
module spi_ss_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic        PCLK,
    input  logic        PRESET_n,
    input  logic        mstr_i,
    input  logic        spiswai_i,
    input  logic [1:0]  spi_mode_i,
    input  logic        send_data_i,
    input  logic [11:0] BaudRateDivisor_i,
    output logic        ss_o,
    output logic        tip_o,
    output logic        receive_data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] tgt_q, tgt_n;
    logic             ss_q, ss_n;
    logic             tip_q, tip_n;
    logic             rx_q, rx_n;

    logic             enable;
    logic [11:0]      div_w;
    logic [CNT_W-1:0] target_w;

    assign enable = mstr_i &
                    ((spi_mode_i == 2'b00) |
                     ((spi_mode_i == 2'b01) & ~spiswai_i));

    // Divisors below 2 cannot form an SCLK period, so clamp to 2.
    assign div_w    = (BaudRateDivisor_i < 12'd2) ? 12'd2 : BaudRateDivisor_i;
    assign target_w = CNT_W'(DATA_BITS) * {{(CNT_W-12){1'b0}}, div_w};

    always_ff @(posedge PCLK) begin
        if (!PRESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ss_q    <= 1'b1;
            tip_q   <= 1'b0;
            rx_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            tgt_q   <= tgt_n;
            ss_q    <= ss_n;
            tip_q   <= tip_n;
            rx_q    <= rx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        tgt_n   = tgt_q;
        ss_n    = ss_q;
        tip_n   = tip_q;
        rx_n    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && send_data_i) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                    tgt_n   = target_w;
                    ss_n    = 1'b0;
                    tip_n   = 1'b1;
                end
            end
            BUSY: begin
`ifdef SPI_SS_ABORT_EN
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ss_n    = 1'b1;
                    tip_n   = 1'b0;
                end else
`endif
                if (cnt_q == tgt_q - ONE) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ss_n    = 1'b1;
                    tip_n   = 1'b0;
                    rx_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q + ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ss_o           = ss_q;
    assign tip_o          = tip_q;
    assign receive_data_o = rx_q;

endmodule

// File: tb/tb_spi_ss_ctrl.sv
// Directed self-checking bench for spi_ss_ctrl.
// Abort expectations follow SPI_SS_ABORT_EN when it is defined.
module tb_spi_ss_ctrl;

    logic        PCLK;
    logic        PRESET_n;
    logic        mstr_i;
    logic        spiswai_i;
    logic [1:0]  spi_mode_i;
    logic        send_data_i;
    logic [11:0] BaudRateDivisor_i;
    logic        ss_o;
    logic        tip_o;
    logic        receive_data_o;

    int checks = 0;
    int errors = 0;

    spi_ss_ctrl dut (
        .PCLK              (PCLK),
        .PRESET_n          (PRESET_n),
        .mstr_i            (mstr_i),
        .spiswai_i         (spiswai_i),
        .spi_mode_i        (spi_mode_i),
        .send_data_i       (send_data_i),
        .BaudRateDivisor_i (BaudRateDivisor_i),
        .ss_o              (ss_o),
        .tip_o             (tip_o),
        .receive_data_o    (receive_data_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge where ss_o is first seen low; returns at
    // the first negedge where it is high again.
    task automatic count_low(output int n, output bit bad);
        n   = 0;
        bad = 1'b0;
        while (ss_o === 1'b0 && n < 40000) begin
            if (tip_o !== 1'b1 || receive_data_o !== 1'b0) bad = 1'b1;
            n++;
            @(negedge PCLK);
        end
    endtask

    // Pulse send for one cycle and measure the resulting window.
    task automatic pulse_window(input string tag, input int exp_len);
        int n;
        bit bad;
        send_data_i = 1'b1;
        @(negedge PCLK);
        send_data_i = 1'b0;
        count_low(n, bad);
        check({tag, "_len"}, n, exp_len);
        check({tag, "_tip"}, {31'd0, bad}, 0);
        check({tag, "_rx"}, {31'd0, receive_data_o}, 1);
        @(negedge PCLK);
        check({tag, "_rx_off"}, {31'd0, receive_data_o}, 0);
    endtask

    // Hold send for several cycles under gating; nothing may start.
    task automatic gated(input string tag);
        bit moved;
        moved = 1'b0;
        send_data_i = 1'b1;
        repeat (4) begin
            @(negedge PCLK);
            if (ss_o !== 1'b1 || tip_o !== 1'b0 || receive_data_o !== 1'b0)
                moved = 1'b1;
        end
        send_data_i = 1'b0;
        check(tag, {31'd0, moved}, 0);
    endtask

    initial begin
        int n;
        int tot;
        bit bad;

        PRESET_n          = 1'b0;
        mstr_i            = 1'b1;
        spiswai_i         = 1'b0;
        spi_mode_i        = 2'b00;
        send_data_i       = 1'b0;
        BaudRateDivisor_i = 12'd4;

        // Reset
        repeat (2) @(negedge PCLK);
        check("rst_ss", {31'd0, ss_o}, 1);
        check("rst_tip", {31'd0, tip_o}, 0);
        check("rst_rx", {31'd0, receive_data_o}, 0);
        PRESET_n = 1'b1;
        @(negedge PCLK);

        // Run mode, div 4
        pulse_window("run_div4", 32);

        // Gating
        spi_mode_i = 2'b01; spiswai_i = 1'b1;
        gated("gate_wait_swai");
        spi_mode_i = 2'b00; spiswai_i = 1'b0; mstr_i = 1'b0;
        gated("gate_mstr0");
        mstr_i = 1'b1; spi_mode_i = 2'b10;
        gated("gate_stop10");
        spi_mode_i = 2'b11;
        gated("gate_stop11");
        spi_mode_i = 2'b01; spiswai_i = 1'b0;
        pulse_window("wait_run", 32);
        spi_mode_i = 2'b00;

        // Divisor clamp and maximum
        BaudRateDivisor_i = 12'd0;
        pulse_window("div0", 16);
        BaudRateDivisor_i = 12'd1;
        pulse_window("div1", 16);
        BaudRateDivisor_i = 12'd4095;
        pulse_window("div4095", 32760);

        // Held request, divisor change mid-window
        BaudRateDivisor_i = 12'd4;
        send_data_i = 1'b1;
        @(negedge PCLK);
        repeat (9) @(negedge PCLK);
        BaudRateDivisor_i = 12'd8;
        count_low(n, bad);
        check("hold_first_len", 9 + n, 32);
        check("hold_first_tip", {31'd0, bad}, 0);
        check("hold_pulse", {31'd0, receive_data_o}, 1);
        @(negedge PCLK);
        send_data_i = 1'b0;
        check("hold_restart_ss", {31'd0, ss_o}, 0);
        count_low(n, bad);
        check("hold_second_len", n, 64);
        check("hold_second_rx", {31'd0, receive_data_o}, 1);
        @(negedge PCLK);
        check("hold_idle_ss", {31'd0, ss_o}, 1);

        // Enable drop at cycle 10 of a div 4 window
        BaudRateDivisor_i = 12'd4;
        send_data_i = 1'b1;
        @(negedge PCLK);
        send_data_i = 1'b0;
        repeat (9) @(negedge PCLK);
        mstr_i = 1'b0;
        count_low(n, bad);
        tot = 9 + n;
`ifdef SPI_SS_ABORT_EN
        check("abort_len", tot, 10);
        check("abort_rx", {31'd0, receive_data_o}, 0);
`else
        check("noabort_len", tot, 32);
        check("noabort_rx", {31'd0, receive_data_o}, 1);
`endif
        @(negedge PCLK);
        check("abort_rx_after", {31'd0, receive_data_o}, 0);
        mstr_i = 1'b1;
        repeat (2) @(negedge PCLK);

        // Reset at cycle 10
        send_data_i = 1'b1;
        @(negedge PCLK);
        send_data_i = 1'b0;
        repeat (9) @(negedge PCLK);
        check("mid_ss_low", {31'd0, ss_o}, 0);
        PRESET_n = 1'b0;
        @(negedge PCLK);
        check("midrst_ss", {31'd0, ss_o}, 1);
        check("midrst_tip", {31'd0, tip_o}, 0);
        check("midrst_rx", {31'd0, receive_data_o}, 0);
        PRESET_n = 1'b1;
        @(negedge PCLK);
        check("midrst_rx_after", {31'd0, receive_data_o}, 0);
        check("midrst_ss_after", {31'd0, ss_o}, 1);

        // Normal operation after reset
        pulse_window("post_rst", 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
